// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, write-buffer entry type and MMIO span for data_mem_bridge
package dmem_pkg;
    typedef enum logic [2:0] {IDLE, RD_WAIT, IO_DRAIN, IO_REQ, IO_DONE} state_t;
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wb_entry_t;
    localparam logic [7:0] MMIO_SPAN = 8'hFF;
endpackage

// File: rtl/data_mem_bridge_wbuf_fifo.sv
// wbuf_fifo: circular store buffer with youngest-match lookup for load forwarding
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  wb_entry_t   push_entry,
    input  logic [29:0] lookup_addr,
    output wb_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic        hit,
    output logic [31:0] hit_data
);
    localparam int PW = $clog2(DEPTH);
    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    // Walk oldest to youngest so the last match wins
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW+1)'(i) < cnt_q && mem_q[rd_ptr_q + PW'(i)].addr == lookup_addr) begin
                hit = 1'b1;
                hit_data = mem_q[rd_ptr_q + PW'(i)].data;
            end
        end
    end
    assign head = mem_q[rd_ptr_q];
    assign full = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: routes CPU data accesses to write-buffered RAM or MMIO; DMEM_ERR_EN adds sticky BusErr
module data_mem_bridge
    import dmem_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter int          WBUF_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [31:0]       AddrM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              RamReq,
    input  logic              RamGnt,
    output logic              RamWE,
    output logic [RAM_AW-1:0] RamAddr,
    output logic [31:0]       RamWD,
    input  logic [31:0]       RamRD,
    output logic              IoReq,
    output logic              IoWE,
    output logic [7:0]        IoAddr,
    output logic [31:0]       IoWD,
    input  logic [31:0]       IoRD,
    input  logic              IoAck
`ifdef DMEM_ERR_EN
    ,
    output logic              BusErr
`endif
);
    state_t state_q, state_d;
    logic io_req_q, io_req_d, io_we_q, io_we_d;
    logic [7:0] io_addr_q, io_addr_d;
    logic [31:0] io_wd_q, io_wd_d, io_rd_q, io_rd_d, hit_data;
    logic is_io, is_st, is_ld, idle, want_rd, rd_issue, drain, push, start_io, full, empty, hit;
    logic [RAM_AW-1:0] ram_wa;
    wb_entry_t head, push_entry;
    assign is_io = AddrM >= MMIO_BASE && AddrM <= MMIO_BASE + 32'(MMIO_SPAN);
    assign ram_wa = AddrM[RAM_AW+1:2];
    assign is_st = MemWriteM;
    assign is_ld = MemReadM & ~MemWriteM;
    assign idle = state_q == IDLE;
    assign want_rd = idle && is_ld && !is_io && !hit;
    assign rd_issue = want_rd && RamGnt;
    assign drain = !empty && RamGnt && !rd_issue;
    assign push = idle && is_st && !is_io && (!full || drain);
    assign start_io = empty && ((idle && is_io && (is_st || is_ld)) || state_q == IO_DRAIN);
    assign push_entry = '{addr: 30'(ram_wa), data: WriteDataM};
    wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk(CLK),
        .rst_n(Reset),
        .push(push),
        .pop(drain),
        .push_entry(push_entry),
        .lookup_addr(30'(ram_wa)),
        .head(head),
        .full(full),
        .empty(empty),
        .hit(hit),
        .hit_data(hit_data)
    );
    assign RamReq = want_rd || !empty;
    assign RamWE = drain;
    assign RamAddr = want_rd ? ram_wa : drain ? RAM_AW'(head.addr) : '0;
    assign RamWD = drain ? head.data : '0;
    assign IoReq = io_req_q;
    assign IoWE = io_we_q;
    assign IoAddr = io_addr_q;
    assign IoWD = io_wd_q;
    always_comb begin
        state_d = state_q;
        io_req_d = io_req_q;
        io_we_d = io_we_q;
        io_addr_d = io_addr_q;
        io_wd_d = io_wd_q;
        io_rd_d = io_rd_q;
        StallM = 1'b0;
        ReadDataM = '0;
        unique case (state_q)
            IDLE: begin
                if (is_io && (is_st || is_ld)) begin
                    StallM = 1'b1;
                    state_d = empty ? IO_REQ : IO_DRAIN;
                end else if (is_st) begin
                    StallM = !push;
                end else if (is_ld) begin
                    StallM = !hit;
                    ReadDataM = hit ? hit_data : '0;
                    state_d = rd_issue ? RD_WAIT : IDLE;
                end
            end
            RD_WAIT: begin
                ReadDataM = RamRD;
                state_d = IDLE;
            end
            IO_DRAIN: begin
                StallM = 1'b1;
                state_d = empty ? IO_REQ : IO_DRAIN;
            end
            IO_REQ: begin
                StallM = 1'b1;
                if (IoAck) begin
                    state_d = IO_DONE;
                    io_req_d = 1'b0;
                    io_we_d = 1'b0;
                    io_rd_d = IoRD;
                end
            end
            IO_DONE: begin
                ReadDataM = io_rd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start_io) begin
            io_req_d = 1'b1;
            io_we_d = is_st;
            io_addr_d = 8'(AddrM - MMIO_BASE);
            io_wd_d = WriteDataM;
        end
    end
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= IDLE;
            io_req_q <= 1'b0;
            io_we_q <= 1'b0;
            io_addr_q <= '0;
            io_wd_q <= '0;
            io_rd_q <= '0;
        end else begin
            state_q <= state_d;
            io_req_q <= io_req_d;
            io_we_q <= io_we_d;
            io_addr_q <= io_addr_d;
            io_wd_q <= io_wd_d;
            io_rd_q <= io_rd_d;
        end
    end
`ifdef DMEM_ERR_EN
    logic err_q, err_d;
    always_comb err_d = err_q || ((MemWriteM || MemReadM) &&
        (AddrM[1:0] != 2'b00 || (!is_io && (AddrM >> (RAM_AW + 2)) != 32'd0)));
    always_ff @(posedge CLK) err_q <= !Reset ? 1'b0 : err_d;
    assign BusErr = err_q;
`endif
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed and randomized checks of data_mem_bridge against RAM/MMIO models
module tb_data_mem_bridge;
    localparam logic [31:0] MB = 32'h0001_0000;
    logic CLK = 1'b0, Reset = 1'b0, MemWriteM = 1'b0, MemReadM = 1'b0, RamGnt = 1'b0;
    logic [31:0] AddrM = '0, WriteDataM = '0;
    logic [31:0] ReadDataM, RamWD, IoWD;
    logic [31:0] RamRD = '0, IoRD = '0;
    logic StallM, RamReq, RamWE, IoReq, IoWE;
    logic IoAck = 1'b0;
    logic [9:0] RamAddr;
    logic [7:0] IoAddr;
`ifdef DMEM_ERR_EN
    logic bus_err;
`endif
    int n_pass = 0, n_tot = 0, n_fail = 0;
    int io_dly = 3;
    logic [31:0] ram [1024];
    logic [31:0] io_regs [64];
    logic io_pend = 1'b0;
    int io_cnt = 0;
    logic [31:0] ref_ram [8];
    logic [31:0] ref_io [4];

    always #5 CLK = ~CLK;

    data_mem_bridge dut (
        .CLK(CLK), .Reset(Reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
        .RamReq(RamReq), .RamGnt(RamGnt), .RamWE(RamWE), .RamAddr(RamAddr),
        .RamWD(RamWD), .RamRD(RamRD), .IoReq(IoReq), .IoWE(IoWE), .IoAddr(IoAddr),
        .IoWD(IoWD), .IoRD(IoRD), .IoAck(IoAck)
`ifdef DMEM_ERR_EN
        , .BusErr(bus_err)
`endif
    );

    always @(posedge CLK) begin
        if (RamReq && RamGnt) begin
            if (RamWE) ram[RamAddr] <= RamWD;
            else RamRD <= ram[RamAddr];
        end
    end

    always @(posedge CLK) begin
        IoAck <= 1'b0;
        if (io_pend) begin
            if (io_cnt == 0) begin
                IoAck <= 1'b1;
                io_pend <= 1'b0;
                if (IoWE) io_regs[IoAddr[7:2]] <= IoWD;
                IoRD <= io_regs[IoAddr[7:2]];
            end else begin
                io_cnt <= io_cnt - 1;
            end
        end else if (IoReq && !IoAck) begin
            io_pend <= 1'b1;
            io_cnt <= io_dly;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic g);
        @(posedge CLK);
        #1;
        MemWriteM = w;
        MemReadM = r;
        AddrM = a;
        WriteDataM = d;
        RamGnt = g;
        #4;
    endtask

    task automatic idle(input logic g);
        drive(1'b0, 1'b0, 32'h0, 32'h0, g);
    endtask

    task automatic finish_op(input string tag, input logic chk_rd, input logic [31:0] exp, input logic rnd_gnt);
        int n;
        n = 0;
        while (StallM === 1'b1 && n < 60) begin
            drive(MemWriteM, MemReadM, AddrM, WriteDataM, rnd_gnt ? ($urandom_range(0, 3) != 0) : 1'b1);
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, StallM}, 32'h0);
        if (chk_rd) chk(tag, ReadDataM, exp);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        MemWriteM = 1'b0;
        MemReadM = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        #4;
    endtask

    initial begin
        int n;
        logic [31:0] w, r, a, d;
        int k;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b1;
        #4;
        chk("reset_ctl", {27'b0, StallM, RamReq, RamWE, IoReq, IoWE}, 32'h0);
        chk("reset_rdata", ReadDataM, 32'h0);
        chk("reset_addr", {14'b0, IoAddr, RamAddr}, 32'h0);
        chk("reset_wdata", RamWD | IoWD, 32'h0);
        drive(1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
        chk("ld40_no_forward", {31'b0, StallM}, 32'h1);
        idle(1'b0);

        drive(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1);
        chk("st40_stall", {31'b0, StallM}, 32'h0);
        idle(1'b1);
        chk("drain_we", {31'b0, RamWE}, 32'h1);
        chk("drain_addr", {22'b0, RamAddr}, 32'h010);
        chk("drain_wd", RamWD, 32'hDEADBEEF);
        idle(1'b1);
        chk("drain_empty", {31'b0, RamReq}, 32'h0);

        drive(1'b1, 1'b0, 32'h40, 32'h11, 1'b0);
        drive(1'b1, 1'b0, 32'h40, 32'h22, 1'b0);
        drive(1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
        chk("fwd_youngest", ReadDataM, 32'h22);
        chk("fwd_stall", {31'b0, StallM}, 32'h0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("fwd_drained", {31'b0, RamReq}, 32'h0);
        drive(1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
        finish_op("ram_ld40", 1'b1, 32'h22, 1'b0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
            chk("fill_stall", {31'b0, StallM}, 32'h0);
        end
        drive(1'b1, 1'b0, 32'h110, 32'hA4, 1'b0);
        chk("full_stall", {31'b0, StallM}, 32'h1);
        drive(1'b1, 1'b0, 32'h110, 32'hA4, 1'b1);
        chk("full_enq_deq", {31'b0, StallM}, 32'h0);
        chk("full_deq_we", {31'b0, RamWE}, 32'h1);
        chk("full_deq_addr", {22'b0, RamAddr}, 32'h040);
        chk("full_deq_wd", RamWD, 32'hA0);
        drive(1'b0, 1'b1, 32'h110, 32'h0, 1'b0);
        chk("fwd_after_wrap", ReadDataM, 32'hA4);
        repeat (4) idle(1'b1);
        idle(1'b1);
        chk("full_drained", {31'b0, RamReq}, 32'h0);

        drive(1'b1, 1'b0, 32'h80, 32'h1234, 1'b1);
        idle(1'b1);
        drive(1'b0, 1'b1, 32'h80, 32'h0, 1'b1);
        chk("miss_stall", {31'b0, StallM}, 32'h1);
        chk("miss_addr", {22'b0, RamAddr}, 32'h020);
        chk("miss_we", {31'b0, RamWE}, 32'h0);
        drive(1'b0, 1'b1, 32'h80, 32'h0, 1'b1);
        chk("miss_stall_done", {31'b0, StallM}, 32'h0);
        chk("miss_data", ReadDataM, 32'h1234);
        idle(1'b0);

        drive(1'b1, 1'b0, 32'h200, 32'h1, 1'b0);
        drive(1'b1, 1'b0, 32'h204, 32'h2, 1'b0);
        drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b0);
        chk("io_wait_stall", {31'b0, StallM}, 32'h1);
        chk("io_wait_req0", {31'b0, IoReq}, 32'h0);
        drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b0);
        chk("io_wait_req1", {31'b0, IoReq}, 32'h0);
        drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b1);
        chk("io_drain1", {30'b0, IoReq, RamWE}, 32'h1);
        drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b1);
        chk("io_drain2", {30'b0, IoReq, RamWE}, 32'h1);
        drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b1);
        chk("io_drained_req0", {31'b0, IoReq}, 32'h0);
        drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b1);
        chk("io_req", {31'b0, IoReq}, 32'h1);
        chk("io_we", {31'b0, IoWE}, 32'h1);
        chk("io_addr", {24'b0, IoAddr}, 32'h04);
        chk("io_wd", IoWD, 32'h55);
        n = 0;
        while (StallM === 1'b1 && n < 20) begin
            chk("io_req_held", {23'b0, IoReq, IoAddr}, 32'h104);
            drive(1'b1, 1'b0, MB + 32'h4, 32'h55, 1'b1);
            n++;
        end
        chk("io_st_timeout", {31'b0, StallM}, 32'h0);
        chk("io_reg1", io_regs[1], 32'h55);
        idle(1'b1);
        drive(1'b0, 1'b1, MB + 32'h4, 32'h0, 1'b1);
        finish_op("io_ld4", 1'b1, 32'h55, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive(1'b1, 1'b0, (32'h300 + 32'(i)) << 2, d, 1'b1);
            finish_op("init_st", 1'b0, 32'h0, 1'b0);
            ref_ram[i] = d;
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            drive(1'b1, 1'b0, MB + 32'(4 * i), d, 1'b1);
            finish_op("init_io", 1'b0, 32'h0, 1'b0);
            ref_io[i] = d;
        end
        for (int t = 0; t < 300; t++) begin
            io_dly = int'($urandom_range(0, 3));
            k = int'($urandom_range(0, 9));
            w = $urandom_range(0, 7);
            r = w % 4;
            d = $urandom;
            a = ((32'h300 + w) << 2) + (($urandom_range(0, 1) == 1) ? 32'h2000 : 32'h0);
            if (k < 4) begin
                drive(1'b1, 1'b0, a, d, $urandom_range(0, 3) != 0);
                finish_op("rnd_st_ram", 1'b0, 32'h0, 1'b1);
                ref_ram[w] = d;
            end else if (k < 8) begin
                drive(1'b0, 1'b1, a, 32'h0, $urandom_range(0, 3) != 0);
                finish_op("rnd_ld_ram", 1'b1, ref_ram[w], 1'b1);
            end else if (k == 8) begin
                drive(1'b1, 1'b0, MB + (r << 2), d, $urandom_range(0, 3) != 0);
                finish_op("rnd_st_io", 1'b0, 32'h0, 1'b1);
                ref_io[r] = d;
            end else begin
                drive(1'b0, 1'b1, MB + (r << 2), 32'h0, $urandom_range(0, 3) != 0);
                finish_op("rnd_ld_io", 1'b1, ref_io[r], 1'b1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3) != 0);
        end

        idle(1'b1);
        io_dly = 6;
        drive(1'b0, 1'b1, MB + 32'h8, 32'h0, 1'b1);
        drive(1'b0, 1'b1, MB + 32'h8, 32'h0, 1'b1);
        chk("rst_io_pending", {31'b0, IoReq}, 32'h1);
        do_reset();
        chk("rst_io_drop", {30'b0, IoReq, StallM}, 32'h0);
        repeat (10) idle(1'b0);
        chk("late_ack_ignored", {30'b0, IoReq, StallM}, 32'h0);
        chk("late_ack_rdata", ReadDataM, 32'h0);
        drive(1'b1, 1'b0, 32'h300 << 2, 32'h999, 1'b0);
        do_reset();
        idle(1'b1);
        chk("rst_flush", {31'b0, RamReq}, 32'h0);
        drive(1'b0, 1'b1, 32'h300 << 2, 32'h0, 1'b1);
        finish_op("rst_discard_ld", 1'b1, ref_ram[0], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1);
    end
endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Memory-stage consumer of the pipelined CPU's data-memory interface: MemWrite, ALU address and store data.
- Routes each access to either a shared synchronous block RAM or a word-wide MMIO peripheral port.
- RAM stores are absorbed by a small write buffer, with read-after-write forwarding from it.
- Asserts StallM whenever an access cannot complete in the cycle it is presented.

Parameters:
- RAM_AW, 10: RAM word-address width (1024 words).
- WBUF_DEPTH, 4: write-buffer entries; power of two, at least 2.
- MMIO_BASE, 32'h0001_0000: start of MMIO region; region covers MMIO_BASE to MMIO_BASE+0xFF.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- MemWriteM  in  1  store request.
- MemReadM  in  1  load request.
- AddrM  in  32  byte address; bits [1:0] ignored (word accesses only).
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data, valid in the cycle StallM=0 with MemReadM=1.
- StallM  out  1  hold pipeline; CPU keeps the request stable while it is 1.
- RamReq  out  1  bridge wants the RAM port this cycle.
- RamGnt  in  1  RAM port granted this cycle (shared with another master).
- RamWE  out  1  RAM write enable.
- RamAddr  out  RAM_AW  RAM word address.
- RamWD  out  32  RAM write data.
- RamRD  in  32  RAM read data; synchronous, valid the cycle after the address.
- IoReq  out  1  MMIO request, held until IoAck.
- IoWE  out  1  MMIO write.
- IoAddr  out  8  MMIO byte offset, AddrM-MMIO_BASE.
- IoWD  out  32  MMIO write data.
- IoRD  in  32  MMIO read data, valid with IoAck.
- IoAck  in  1  MMIO completion, single-cycle pulse.

Behaviour:
- Reset (Reset=0 at an edge): buffer emptied (pending writes discarded), FSM to IDLE. Outputs: StallM, RamReq, RamWE, IoReq, IoWE all 0; ReadDataM, RamAddr, RamWD, IoAddr, IoWD 0.
- Address decode: AddrM in [MMIO_BASE, MMIO_BASE+0xFF] selects MMIO; anything else selects RAM with word address AddrM[RAM_AW+1:2]. Upper RAM bits alias.
- MemWriteM and MemReadM both 1: treated as a store; the read is ignored.
- Write buffer: circular FIFO of {word addr, data}.
  - RAM store in IDLE enqueues at the edge. StallM=1 only if the buffer is full and no dequeue happens that cycle.
  - Enqueue and dequeue in the same cycle is allowed when full.
- Drain: head entry is written (RamReq=1, RamWE=1) in any cycle with a non-empty buffer, RamGnt=1 and no RAM read issuing. Dequeue occurs at that edge.
- RAM load, forward hit: any buffer entry matches the word address.
  - ReadDataM = data of the youngest match, combinationally, StallM=0.
  - A store enqueued in cycle N is forwardable from cycle N+1.
- RAM load, no hit: needs RamGnt=1 to issue.
  - Issue cycle: RamReq=1, RamWE=0, RamAddr driven, StallM=1, FSM to RD_WAIT.
  - Next cycle: ReadDataM=RamRD, StallM=0, FSM to IDLE.
  - No grant: StallM=1, retry next cycle.
- FSM states:
  - IDLE: RAM hits and stores complete here as above.
  - RD_WAIT: one cycle; drain is permitted.
  - IO_DRAIN: entered on an MMIO access with a non-empty buffer; stay, StallM=1, until empty.
  - IO_REQ: IoReq=1, IoWE, IoAddr, IoWD stable, StallM=1, until IoAck.
  - IO_DONE: one cycle; ReadDataM = IoRD captured at IoAck, StallM=0; back to IDLE.
- MMIO access with an empty buffer goes straight from IDLE to IO_REQ.
- MMIO loads never forward from the buffer.
- Every MMIO access therefore costs at least 2 stalled cycles plus the ack latency.
- Reset mid-operation: an outstanding IoReq drops at the next edge; a late IoAck is ignored.
- Pointer wrap: modulo WBUF_DEPTH. Count width is $clog2(WBUF_DEPTH)+1 so full and empty are distinct.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: adds output BusErr (1 bit, sticky, cleared only by reset). Set on:
  - an access with AddrM[1:0]!=0;
  - a RAM-decoded address with any bit above RAM_AW+1 set.
- The access itself still proceeds as above.
- Undefined: no BusErr port; no detection logic.

Decomposition:
- Package dmem_pkg:
  - FSM state enum (IDLE, RD_WAIT, IO_DRAIN, IO_REQ, IO_DONE);
  - write-buffer entry struct {addr, data};
  - MMIO_SPAN constant 8'hFF.
- Sub-module wbuf_fifo: circular buffer with parallel youngest-match lookup (hit, data). Bridge FSM, decode and RAM/MMIO muxing stay in data_mem_bridge.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> StallM=0, RamReq=0, IoReq=0, buffer empty; a load of 0x40 does not forward.
- RamGnt=1, store 0xDEADBEEF to 0x40 -> next cycle RamWE=1, RamAddr=0x010, RamWD=0xDEADBEEF; buffer empty after.
- RamGnt=0, stores 0x40<-0x11, then 0x40<-0x22, then load 0x40 -> ReadDataM=0x22 in the load cycle, StallM=0.
- RamGnt=0, five stores -> fifth has StallM=1. Raise RamGnt for one cycle -> fifth accepted, first entry written to RAM.
- RAM word 0x20 = 0x1234, load 0x80, RamGnt=1, no hit -> StallM=1 for one cycle, then ReadDataM=0x1234.
- Two RAM stores pending with RamGnt=0, then store 0x55 to MMIO_BASE+4 -> IoReq stays 0 until both drain after RamGnt=1. Then IoReq=1, IoAddr=0x04, IoWD=0x55, held through a 3-cycle-delayed IoAck; StallM falls in IO_DONE.
